// File: rtl/alu_wb_result_fifo_pkg.sv
// Shared types for the ALU writeback result queue.
// Carries the core-wide widths so that no block introduces its own copies.
package alu_wb_result_fifo_pkg;

   localparam int XLEN         = 32;
   localparam int LOG2_MAX_IDS = 3;
   localparam int ALU_WB_DEPTH = 4;

   typedef logic [LOG2_MAX_IDS-1:0] id_t;

   typedef struct packed {
      id_t             id;
      logic [XLEN-1:0] rd;
   } alu_wb_entry_t;

   function automatic alu_wb_entry_t make_entry(input id_t id, input logic [XLEN-1:0] rd);
      alu_wb_entry_t e;
      e.id = id;
      e.rd = rd;
      return e;
   endfunction

endpackage

// File: rtl/alu_wb_result_fifo_if.sv
// ALU-completion and writeback handshake seen by the result queue.
// The slave side is the queue itself; the master side is the ALU plus writeback arbiter.
interface alu_wb_result_fifo_if;
   import alu_wb_result_fifo_pkg::*;

   logic            in_done;
   id_t             in_id;
   logic [XLEN-1:0] in_rd;
   logic            issue_rdy;

   logic            wb_valid;
   id_t             wb_id;
   logic [XLEN-1:0] wb_rd;
   logic            wb_ack;

   modport slave (
      input  in_done, in_id, in_rd, wb_ack,
      output issue_rdy, wb_valid, wb_id, wb_rd
   );

   modport master (
      output in_done, in_id, in_rd, wb_ack,
      input  issue_rdy, wb_valid, wb_id, wb_rd
   );

endinterface

// File: rtl/alu_wb_result_fifo.sv
// In-order queue holding completed ALU results until the writeback arbiter accepts them.
// All outputs come straight from flops; nothing on in_* or wb_ack reaches them combinationally.
module alu_wb_result_fifo
   import alu_wb_result_fifo_pkg::*;
#(
   parameter  int DEPTH = ALU_WB_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   alu_wb_result_fifo_if.slave   bus,
   output logic [CNT_W-1:0]      count,
   output logic                  overflow
);

   alu_wb_entry_t    mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   alu_wb_entry_t    head_q;
   logic             valid_q;
   logic             rdy_q;

   logic             full;
   logic             push;
   logic             pop;
   alu_wb_entry_t    in_entry;
   logic [PTR_W-1:0] rd_ptr_nxt;
   logic [PTR_W-1:0] wr_ptr_nxt;
   logic [CNT_W-1:0] count_nxt;
   alu_wb_entry_t    head_nxt;

   assign full     = (count == CNT_W'(DEPTH));
   assign push     = bus.in_done & ~full;
   assign pop      = bus.wb_ack & valid_q;
   assign in_entry = make_entry(bus.in_id, bus.in_rd);

   always_comb begin
      rd_ptr_nxt = rd_ptr;
      wr_ptr_nxt = wr_ptr;
      count_nxt  = count;
      head_nxt   = head_q;
      if (flush) begin
         rd_ptr_nxt = '0;
         wr_ptr_nxt = '0;
         count_nxt  = '0;
      end else begin
         if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
         count_nxt = count + CNT_W'(push) - CNT_W'(pop);
      end
      // Next head is either the slot being written this edge or one already stored.
      if (push && !flush && (wr_ptr == rd_ptr_nxt)) begin
         head_nxt = in_entry;
      end else begin
         head_nxt = mem[rd_ptr_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
         rdy_q    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (push && !flush) mem[wr_ptr] <= in_entry;
         rd_ptr  <= rd_ptr_nxt;
         wr_ptr  <= wr_ptr_nxt;
         count   <= count_nxt;
         head_q  <= head_nxt;
         valid_q <= (count_nxt != '0);
         rdy_q   <= (count_nxt != CNT_W'(DEPTH));
         // A full-queue push is a protocol violation even if a flush lands on the same edge.
         if (bus.in_done && full) overflow <= 1'b1;
      end
   end

   assign bus.wb_valid  = valid_q;
   assign bus.wb_id     = head_q.id;
   assign bus.wb_rd     = head_q.rd;
   assign bus.issue_rdy = rdy_q;

   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count <= CNT_W'(DEPTH));

   a_push_full_flags: assert property (@(posedge clk) disable iff (rst)
      (bus.in_done && full) |=> overflow);

   a_head_stable: assert property (@(posedge clk) disable iff (rst)
      (valid_q && !bus.wb_ack && !flush) |=>
         (valid_q && $stable(head_q.id) && $stable(head_q.rd)));

endmodule
